seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; result width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply with current operands.
REQ-005 SHALL have port multiplicand  input  WIDTH  signed (two's complement) operand M.
REQ-006 SHALL have port multiplier  input  WIDTH  signed (two's complement) operand Q.
REQ-007 SHALL have port result  output  2*WIDTH  signed product; high half = HI, low half = LO.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking result valid.
REQ-010 SHALL have port step_count  output  6  number of Booth steps completed in the current operation.

Function
REQ-011 SHALL implement radix-2 Booth multiplication, one recode/add/shift step per clock.
REQ-012 SHALL have an FSM with states IDLE, RUN and DONE, encoded in registered state.
REQ-013 SHALL, in IDLE with start=1 at a rising edge, register M and Q, clear A (WIDTH+1 bits) and Q(-1), clear step_count, and go to RUN.
REQ-014 SHALL, on each RUN edge, examine {Q[0],Q(-1)}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add; then arithmetic-right-shift {A,Q,Q(-1)} by one and increment step_count.
REQ-015 SHALL sign-extend M to WIDTH+1 bits for add/subtract so that M = -2^(WIDTH-1) is handled without overflow.
REQ-016 SHALL, on the edge completing step WIDTH, load result = {A[WIDTH-1:0],Q} and go to DONE.
REQ-017 SHALL assert done for exactly one cycle, in DONE, then return to IDLE on the next edge.
REQ-018 SHALL have latency of exactly WIDTH+1 edges from the start-sampling edge to done falling, with done high during the cycle after edge WIDTH.
REQ-019 SHALL drive busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-020 SHALL ignore start while in RUN or DONE; operands are not resampled mid-operation.
REQ-021 SHALL hold result stable from DONE until the next accepted start completes; result SHALL NOT change during RUN.
REQ-022 SHALL accept start on the first IDLE edge after DONE, allowing back-to-back operations every WIDTH+2 cycles.
REQ-023 SHALL ignore operand input changes after the sampling edge.
REQ-024 SHALL have step_count saturate at WIDTH in DONE and hold until the next accepted start.

Reset
REQ-025 SHALL, while reset=0, immediately force state=IDLE, result=0, busy=0, done=0, step_count=0, and clear A, Q, Q(-1) and M.
REQ-026 SHALL, on reset assertion mid-RUN, abort the operation with no done pulse; result reads 0 afterward.
REQ-027 SHALL, on the first rising edge after reset deasserts, be able to accept start.

Verification
REQ-028 SHALL verify M=3, Q=5, start pulse -> done after 32 edges, result=0x000000000000000F, busy high 33 cycles.
REQ-029 SHALL verify M=-7 (0xFFFFFFF9), Q=3 -> result=0xFFFFFFFFFFFFFFEB; and M=Q=0xFFFFFFFF -> result=0x0000000000000001.
REQ-030 SHALL verify M=Q=0x80000000 -> result=0x4000000000000000; and M=0x80000000, Q=1 -> result=0xFFFFFFFF80000000.
REQ-031 SHALL verify that start held high with operands changed during RUN -> only one done, result from the first operands, next operation starts the edge after DONE.
REQ-032 SHALL verify that reset pulsed low at step_count=10 -> no done, outputs all 0; a new start of 2*2 -> result=4.
REQ-033 SHALL verify 1000 random signed operand pairs checked against a reference product, including zero and ±1 operands.

Source files
------------

// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle between a requester and the sequential Booth multiplier.
// The requester drives start and the operands; the multiplier returns product and status.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;
  logic                   done;
  logic [5:0]             step_count;

  modport master (
    output start, multiplicand, multiplier,
    input  result, busy, done, step_count
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output result, busy, done, step_count
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 Booth signed multiplier: one recode/add/shift step per clock,
// WIDTH steps per product, with a one-cycle done pulse afterwards.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  seq_multiplier_if.slave bus
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [WIDTH:0]       a_reg;
  logic [WIDTH:0]       a_next;
  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH-1:0]     q_next;
  logic                 qm1_reg;
  logic                 qm1_next;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       sum;
  logic [5:0]           step_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 last_step;

  // One extra sign bit keeps A - M exact when M is the most negative value.
  assign m_ext     = {m_reg[WIDTH-1], m_reg};
  assign last_step = (state_reg == RUN) && (step_reg == LAST_STEP);

  always_comb begin
    sum = a_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   sum = a_reg + m_ext;
      2'b10:   sum = a_reg - m_ext;
      default: sum = a_reg;
    endcase
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q_reg[WIDTH-1:1]};
    qm1_next = q_reg[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg      <= '0;
      q_reg      <= '0;
      qm1_reg    <= 1'b0;
      m_reg      <= '0;
      step_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            m_reg    <= bus.multiplicand;
            q_reg    <= bus.multiplier;
            a_reg    <= '0;
            qm1_reg  <= 1'b0;
            step_reg <= '0;
          end
        end
        RUN: begin
          a_reg    <= a_next;
          q_reg    <= q_next;
          qm1_reg  <= qm1_next;
          step_reg <= step_reg + 6'd1;
          // The product is published only once, so result never moves mid-run.
          if (last_step) begin
            result_reg <= {a_next[WIDTH-1:0], q_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.step_count = step_reg;
  assign bus.result     = result_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner products, start-hold,
// mid-run reset and 1000 random products against a cycle-level behavioural model.
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Behavioural model state, owned by the monitor process.
  bit          m_active;
  int          m_cnt;
  int          m_step;
  logic [63:0] m_result;
  logic [63:0] m_prod;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted start begins a WIDTH-step run, done follows in the next
  // cycle, and the operation retires one edge later.
  initial begin
    m_active = 0; m_cnt = 0; m_step = 0; m_result = '0; m_prod = '0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_active = 0; m_cnt = 0; m_step = 0; m_result = '0;
      end else if (!m_active) begin
        if (bus.start) begin
          m_active = 1;
          m_cnt    = 0;
          m_step   = 0;
          m_prod   = mul(bus.multiplicand, bus.multiplier);
        end
      end else begin
        m_cnt++;
        if (m_cnt <= WIDTH) m_step = m_cnt;
        if (m_cnt == WIDTH) m_result = m_prod;
        if (m_cnt == WIDTH + 1) m_active = 0;
      end
      #1;
      check("mon_busy",   64'(bus.busy), 64'(m_active));
      check("mon_done",   64'(bus.done), 64'(m_active && (m_cnt == WIDTH)));
      check("mon_step",   64'(bus.step_count), 64'(m_step));
      check("mon_result", bus.result, m_result);
    end
  end

  // Called at the first falling edge after the start-sampling edge.
  task automatic finish_op(input string nm, input logic [63:0] exp);
    int waits;
    int busy_cnt;
    bit seen;
    waits = 1; busy_cnt = 0; seen = 0;
    while (!seen && waits <= 100) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1;
      else begin
        @(negedge clk);
        waits++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 100 cycles", nm);
    end
    check({nm, "_result"}, bus.result, exp);
    check({nm, "_model"}, m_result, exp);
    check({nm, "_latency"}, 64'(waits), 64'(33));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
    @(negedge clk);
    check({nm, "_busy_after"}, 64'(bus.busy), 64'(0));
    check({nm, "_done_after"}, 64'(bus.done), 64'(0));
    $display("op %s: M=%h Q=%h result=%h", nm, bus.multiplicand, bus.multiplier, bus.result);
  endtask

  // Called at a falling edge with the multiplier idle.
  task automatic op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                    input string nm);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op(nm, exp);
  endtask

  initial begin
    int          waits;
    int          n_done;
    bit          was_busy;
    logic [63:0] cap;
    logic [31:0] rm;
    logic [31:0] rq;

    n_checks = 0;
    n_fail   = 0;
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    repeat (3) @(negedge clk);
    check("reset_result", bus.result, 64'h0);
    check("reset_busy",   64'(bus.busy), 64'(0));
    check("reset_done",   64'(bus.done), 64'(0));
    check("reset_step",   64'(bus.step_count), 64'(0));
    reset = 1'b1;

    op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5");
    check("step_saturated", 64'(bus.step_count), 64'(32));
    op(32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, "m7x3");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1xm1");
    op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin");
    op(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "minx1");

    // Start held high with operands churning during the run.
    bus.multiplicand = 32'd6;
    bus.multiplier   = 32'd7;
    bus.start        = 1'b1;
    waits = 0; n_done = 0; was_busy = 0; cap = '0;
    do begin
      @(negedge clk);
      waits++;
      if (bus.done) begin
        n_done++;
        cap = bus.result;
      end
      if (bus.busy) was_busy = 1;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
    end while (!(was_busy && !bus.busy) && waits < 100);
    check("hold_done_count", 64'(n_done), 64'(1));
    check("hold_result", cap, 64'd42);
    check("hold_retire_cycle", 64'(waits), 64'(34));
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd11;
    @(negedge clk);
    check("hold_restart_busy", 64'(bus.busy), 64'(1));
    check("hold_restart_step", 64'(bus.step_count), 64'(0));
    bus.start = 1'b0;
    finish_op("9x11", 64'd99);

    // Reset in the middle of a run.
    bus.multiplicand = 32'd100;
    bus.multiplier   = 32'd200;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waits = 0;
    while (bus.step_count != 6'd10 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("abort_step10", 64'(bus.step_count), 64'(10));
    reset = 1'b0;
    #1;
    check("abort_result", bus.result, 64'h0);
    check("abort_busy",   64'(bus.busy), 64'(0));
    check("abort_done",   64'(bus.done), 64'(0));
    check("abort_step",   64'(bus.step_count), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'(0));
    end
    reset = 1'b1;
    op(32'd2, 32'd2, 64'd4, "2x2");

    // Random back-to-back products with forced zero and unit operands.
    for (int i = 0; i < 1000; i++) begin
      rm = $urandom;
      rq = $urandom;
      case (i % 10)
        0: rm = 32'd0;
        1: rq = 32'd0;
        2: rm = 32'd1;
        3: rq = 32'hFFFF_FFFF;
        4: rm = 32'hFFFF_FFFF;
        5: rq = 32'd1;
        default: ;
      endcase
      op(rm, rq, mul(rm, rq), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
